// File: rtl/timer_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the timer control stage.
package timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    function automatic int unsigned presc_width(input int unsigned prescale);
        return $clog2(prescale) + 1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler: one o_tick every PRESCALE clocks while i_run is high, parked at 0 otherwise.
module tick_div
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_tick
);

    localparam int unsigned CW = presc_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (!i_run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_tick = i_run && (cnt == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Sequencer driving a one-shot counter: clear/start/enable generation, expiry counting and IRQ.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned NEXP_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    input  logic              i_stop,
    input  logic              i_periodic,
    input  logic              i_irq_ack,
    input  logic              i_expired,
    output logic              o_cnt_en,
    output logic              o_cnt_start,
    output logic              o_cnt_clr,
    output logic              o_busy,
    output logic              o_irq,
    output logic              o_overrun,
    output logic [NEXP_W-1:0] o_exp_cnt
);

    state_t state, state_nx;
    logic   mode;
    logic   tick;
    logic   run;
    logic   go_acc;
    logic   expiry;

    assign run    = (state == ST_START) || (state == ST_RUN);
    assign go_acc = (state == ST_IDLE) && i_go && !i_stop;
    // Stale counter line is masked outside RUN so it never counts.
    assign expiry = (state == ST_RUN) && i_expired;

    tick_div #(
        .PRESCALE(PRESCALE)
    ) u_tick_div (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_run  (run),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (go_acc) state_nx = ST_CLEAR;
            ST_CLEAR: state_nx = i_stop ? ST_ABORT : ST_START;
            ST_START: begin
                if (i_stop)    state_nx = ST_ABORT;
                else if (tick) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (i_stop)      state_nx = ST_ABORT;
                else if (expiry) state_nx = mode ? ST_CLEAR : ST_ABORT;
            end
            ST_ABORT: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode      <= 1'b0;
            o_irq     <= 1'b0;
            o_overrun <= 1'b0;
            o_exp_cnt <= '0;
        end else begin
            if (go_acc) begin
                mode <= i_periodic;
            end

            if (go_acc) begin
                o_exp_cnt <= '0;
            end else if (expiry && o_exp_cnt != '1) begin
                o_exp_cnt <= o_exp_cnt + NEXP_W'(1);
            end

            // A new expiry outranks an acknowledge arriving in the same cycle.
            if (expiry) begin
                o_irq <= 1'b1;
            end else if (i_irq_ack) begin
                o_irq <= 1'b0;
            end

            if (go_acc) begin
                o_overrun <= 1'b0;
            end else if (expiry && o_irq && !i_irq_ack) begin
                o_overrun <= 1'b1;
            end
        end
    end

    assign o_cnt_en    = tick;
    assign o_cnt_start = (state == ST_START);
    assign o_cnt_clr   = (state == ST_CLEAR) || (state == ST_ABORT);
    assign o_busy      = (state != ST_IDLE);

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control stage that sits directly downstream of the one-shot `counter` and drives it.
- Consumes the counter's `o_line` as an expiry flag and generates the counter's enable ticks (prescaler), start pulse and clear pulse.
- Supports one-shot and periodic modes, counts expiries, and raises a latched interrupt with acknowledge and a sticky overrun flag.

Parameters:
- PRESCALE, default 1: clocks per `o_cnt_en` tick. Legal range is 1 and up; 1 means a tick every clock.
- NEXP_W, default 8: width of the expiry counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_go  in  1  start request, sampled only in IDLE.
- i_stop  in  1  abort request.
- i_periodic  in  1  mode, latched on an accepted `i_go` (1 = periodic, 0 = one-shot).
- i_irq_ack  in  1  clears `o_irq`.
- i_expired  in  1  counter `o_line`.
- o_cnt_en  out  1  counter `i_en` tick.
- o_cnt_start  out  1  counter `i_start`.
- o_cnt_clr  out  1  counter reset (active-high pulse).
- o_busy  out  1  high when state is not IDLE.
- o_irq  out  1  latched interrupt.
- o_overrun  out  1  sticky: an expiry occurred while `o_irq` was already pending.
- o_exp_cnt  out  NEXP_W  saturating count of expiries since the last accepted go.

Behaviour:
- Reset (`i_rst_n` = 0, asynchronous):
  - state goes to IDLE; latched mode = 0; prescaler = 0.
  - All outputs are 0, including `o_exp_cnt` = 0.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- States: IDLE, CLEAR, START, RUN, ABORT.
- IDLE:
  - On `i_go` with `i_stop` = 0: latch `i_periodic`, zero `o_exp_cnt` and `o_overrun`, go to CLEAR.
  - `i_go` in any other state is ignored.
- CLEAR: `o_cnt_clr` = 1 for exactly one cycle; prescaler held at 0; next state is START.
- START:
  - `o_cnt_start` = 1 while in START.
  - Leave for RUN on the cycle where `o_cnt_en` = 1, so start and enable coincide.
  - With PRESCALE=1, START lasts one cycle; with PRESCALE=P, it lasts P cycles.
- RUN:
  - `o_cnt_start` = 0.
  - `i_expired` = 1 is an expiry event. It increments `o_exp_cnt`, saturating at all-ones (no wrap), and sets `o_irq`.
  - If `o_irq` was already 1 and `i_irq_ack` = 0 in the same cycle, `o_overrun` is set.
  - After an expiry, periodic mode goes to CLEAR (auto-restart); one-shot mode goes to ABORT.
- ABORT: `o_cnt_clr` = 1 for one cycle, then IDLE. This leaves the counter cleared after every termination.
- `i_stop` in CLEAR, START or RUN goes to ABORT next cycle.
  - `i_stop` has priority over `i_go` and over the periodic restart.
  - `i_stop` together with an expiry in RUN: the expiry is still counted and flagged, then ABORT.
  - `i_stop` in IDLE or ABORT has no effect.
- Prescaler:
  - Counts 0..PRESCALE-1 only in START and RUN, and is held at 0 in other states.
  - `o_cnt_en` = 1 when count = PRESCALE-1 in START or RUN; it is 0 in IDLE, CLEAR and ABORT.
  - Width is clog2(PRESCALE)+1.
- IRQ:
  - `i_irq_ack` clears `o_irq` next cycle.
  - A simultaneous expiry wins: `o_irq` stays 1 and no overrun is flagged.
  - `o_overrun` clears only on reset or an accepted `i_go`.
- `i_expired` is ignored outside RUN, so a stale high level left from the counter before its clear takes effect is never counted.
- Reset asserted mid-operation returns to the reset values immediately, regardless of state.

Decomposition:
- Package `timer_ctrl_pkg`: state encoding constants (IDLE=0, CLEAR=1, START=2, RUN=3, ABORT=4, 3-bit) and the prescaler width function.
- One natural sub-module: `tick_div`, the prescaler.
  - Inputs: i_clk, i_rst_n, i_run.
  - Output: o_tick.
  - Parameter: PRESCALE.

Test Plan:
- PRESCALE=1, one-shot:
  - Stimulus: pulse `i_go` at cycle 0; model `i_expired`=1 at cycle 6.
  - Response: `o_cnt_clr` high in cycle 1; `o_cnt_start` and `o_cnt_en` high in cycle 2; `o_irq` and `o_exp_cnt`=1 in cycle 7; `o_cnt_clr` high in cycle 7; `o_busy` falls in cycle 8.
- PRESCALE=4, periodic, expiry held each pass:
  - Response: `o_cnt_en` pulses every 4th clock; START lasts 4 cycles; CLEAR/START repeat after every expiry.
  - With no ack, `o_overrun`=1 after the 2nd expiry; `o_exp_cnt` counts 1, 2, 3.
- NEXP_W=2, periodic, 5 expiries:
  - Response: `o_exp_cnt` saturates at 3 and does not wrap to 0.
- `i_stop` and expiry in the same RUN cycle:
  - Response: `o_exp_cnt` increments, `o_irq`=1, ABORT clear pulse, then IDLE with no restart.
- `i_irq_ack` coincident with an expiry while `o_irq`=1:
  - Response: `o_irq` stays 1 and `o_overrun` stays 0.
- `i_rst_n` low mid-RUN with `o_irq`=1:
  - Response: all outputs 0 immediately; a subsequent `i_go` behaves as in the first scenario.
